// File: rtl/led_pattern_gen.sv
// Multi-LED pattern generator: a prescaled base tick drives hold/blink/chase/bounce patterns.
// Optional PWM brightness control is enabled by defining LED_PWM_EN.
module led_pattern_gen #(
  parameter int N_LEDS     = 8,
  parameter int TICK_DIV   = 12_000,
  parameter int PER_W      = 10,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [PER_W-1:0]  period,
  input  logic [N_LEDS-1:0] hold_pat,
`ifdef LED_PWM_EN
  input  logic [7:0]        brightness,
`endif
  output logic [N_LEDS-1:0] led,
  output logic              step_pulse
);

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_CHASE  = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam int                PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0]  PRE_MAX = PRE_W'(TICK_DIV - 1);
  localparam logic [N_LEDS-1:0] UNLIT   = {N_LEDS{ACTIVE_LOW}};
  localparam logic [N_LEDS-1:0] BIT0    = N_LEDS'(1);
  localparam bit                SINGLE  = (N_LEDS == 1);

  logic [PRE_W-1:0]  r_pre_cnt;
  logic [PER_W-1:0]  r_step_cnt;
  logic [N_LEDS-1:0] r_pat;
  dir_e              r_dir;
  mode_e             r_mode_q;
  logic              r_step_pulse;
  logic [N_LEDS-1:0] r_led;

  logic [PRE_W-1:0]  w_pre_nxt;
  logic [PER_W-1:0]  w_step_cnt_nxt;
  logic [N_LEDS-1:0] w_pat_nxt;
  dir_e              w_dir_nxt;
  mode_e             w_mode_nxt;
  logic              w_pulse_nxt;

  logic              w_mode_chg;
  logic              w_tick;
  logic [PER_W-1:0]  w_per_m1;
  logic              w_step;
  logic [N_LEDS-1:0] w_lit;

  function automatic logic [N_LEDS-1:0] seed_of(input mode_e m, input logic [N_LEDS-1:0] hp);
    case (m)
      MODE_HOLD:  return hp;
      MODE_BLINK: return '1;
      default:    return BIT0;
    endcase
  endfunction

  assign w_mode_chg = (mode != r_mode_q);
  assign w_tick     = (r_pre_cnt == PRE_MAX);
  // Period 0 behaves as 1; compared live so a shrinking period steps on the next tick.
  assign w_per_m1   = (period == '0) ? '0 : period - 1'b1;
  assign w_step     = w_tick && (r_step_cnt >= w_per_m1);

  always_comb begin : next_state
    // NOTE: every next-state signal gets a default first, so no path can infer a latch.
    w_pre_nxt      = r_pre_cnt;
    w_step_cnt_nxt = r_step_cnt;
    w_pat_nxt      = r_pat;
    w_dir_nxt      = r_dir;
    w_mode_nxt     = r_mode_q;
    w_pulse_nxt    = 1'b0;

    if (w_mode_chg) begin
      w_mode_nxt     = mode_e'(mode);
      w_pre_nxt      = '0;
      w_step_cnt_nxt = '0;
      w_dir_nxt      = DIR_UP;
      w_pat_nxt      = seed_of(mode_e'(mode), hold_pat);
    end else if (en) begin
      w_pre_nxt   = w_tick ? '0 : r_pre_cnt + 1'b1;
      w_pulse_nxt = w_step;
      if (w_tick) begin
        w_step_cnt_nxt = w_step ? '0 : r_step_cnt + 1'b1;
      end

      if (r_mode_q == MODE_HOLD) begin
        w_pat_nxt = hold_pat;
      end else if (w_step) begin
        case (r_mode_q)
          MODE_BLINK: w_pat_nxt = ~r_pat;
          MODE_CHASE: w_pat_nxt = (r_pat << 1) | (r_pat >> (N_LEDS - 1));
          MODE_BOUNCE: begin
            // Reverse at either end before shifting so the lit bit never falls off.
            if (SINGLE) begin
              w_pat_nxt = r_pat;
            end else if (r_dir == DIR_UP) begin
              if (r_pat[N_LEDS-1]) begin
                w_dir_nxt = DIR_DOWN;
                w_pat_nxt = r_pat >> 1;
              end else begin
                w_pat_nxt = r_pat << 1;
              end
            end else begin
              if (r_pat[0]) begin
                w_dir_nxt = DIR_UP;
                w_pat_nxt = r_pat << 1;
              end else begin
                w_pat_nxt = r_pat >> 1;
              end
            end
          end
          default: w_pat_nxt = r_pat;
        endcase
      end
    end
  end

`ifdef LED_PWM_EN
  logic [7:0] r_pwm_cnt;
  logic       w_pwm_on;

  assign w_pwm_on = (r_pwm_cnt < brightness);
  assign w_lit    = r_pat & {N_LEDS{w_pwm_on}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_cnt <= 8'd0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 8'd1;
    end
  end
`else
  assign w_lit = r_pat;
`endif

  always_ff @(posedge clk or negedge rst_n) begin : state_reg
    if (!rst_n) begin
      r_pre_cnt    <= '0;
      r_step_cnt   <= '0;
      r_pat        <= '0;
      r_dir        <= DIR_UP;
      r_mode_q     <= MODE_HOLD;
      r_step_pulse <= 1'b0;
      r_led        <= UNLIT;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_pre_cnt    <= w_pre_nxt;
      r_step_cnt   <= w_step_cnt_nxt;
      r_pat        <= w_pat_nxt;
      r_dir        <= w_dir_nxt;
      r_mode_q     <= w_mode_nxt;
      r_step_pulse <= w_pulse_nxt;
      r_led        <= w_lit ^ UNLIT;
    end
  end

  assign led        = r_led;
  assign step_pulse = r_step_pulse;

endmodule
